// File: rtl/ocx_tlx_data_run_ctl.sv
// rtl/ocx_tlx_data_run_ctl.sv - tracks control/data flit runs and issues bookend BDI for ocx_tlx_bdi_mac
module ocx_tlx_data_run_ctl #(
   parameter logic [3:0] max_run    = 4'd8,
   parameter logic       err_sticky = 1'b0
) (
   input  logic       tlx_clk,
   input  logic       reset_n,
   input  logic       flit_v,
   input  logic       flit_is_ctl,
   input  logic [3:0] ctl_run_length,
   input  logic [7:0] ctl_bdi,
   input  logic       crc_error,
   output logic       ctl_flit_start,
   output logic [3:0] run_length,
   output logic       bookend_flit_v,
   output logic [7:0] bad_data_indicator,
   output logic       data_flit_v,
   output logic [2:0] data_flit_idx,
   output logic       run_err
);

   typedef enum logic [1:0] {IDLE, RUN, WAIT_BE} state_t;

   state_t     state_q, state_d;
   logic [3:0] remaining_q, remaining_d;
   logic [3:0] rcvd_q, rcvd_d;

   logic       ctl_flit_start_d;
   logic [3:0] run_length_d;
   logic       bookend_flit_v_d;
   logic [7:0] bad_data_indicator_d;
   logic       data_flit_v_d;
   logic [2:0] data_flit_idx_d;
   logic       run_err_d;
   logic       err_evt;
   logic [8:0] rcvd_mask;

   // Low rcvd bits set; the 9-bit shift makes rcvd=8 yield 8'hFF without overflow.
   assign rcvd_mask = (9'd1 << rcvd_q) - 9'd1;

   always_comb begin
      state_d              = state_q;
      remaining_d          = remaining_q;
      rcvd_d               = rcvd_q;
      ctl_flit_start_d     = 1'b0;
      run_length_d         = 4'd0;
      bookend_flit_v_d     = 1'b0;
      bad_data_indicator_d = 8'd0;
      data_flit_v_d        = 1'b0;
      data_flit_idx_d      = 3'd0;
      err_evt              = 1'b0;

      if (crc_error) begin
         state_d     = IDLE;
         remaining_d = 4'd0;
         rcvd_d      = 4'd0;
      end else if (flit_v && flit_is_ctl) begin
         ctl_flit_start_d = 1'b1;
         if (rcvd_q != 4'd0) begin
            bookend_flit_v_d     = 1'b1;
            bad_data_indicator_d = ctl_bdi & rcvd_mask[7:0];
         end
         if (state_q == RUN && remaining_q != 4'd0) begin
            err_evt = 1'b1;
         end
         // The bookend consumes the open run; counters restart whatever the new length is.
         state_d     = IDLE;
         remaining_d = 4'd0;
         rcvd_d      = 4'd0;
         if (ctl_run_length != 4'd0 && ctl_run_length <= max_run) begin
            run_length_d = ctl_run_length;
            remaining_d  = ctl_run_length;
            state_d      = RUN;
         end else if (ctl_run_length > max_run) begin
            err_evt = 1'b1;
         end
      end else if (flit_v) begin
         if (state_q == RUN && remaining_q != 4'd0) begin
            data_flit_v_d   = 1'b1;
            data_flit_idx_d = rcvd_q[2:0];
            rcvd_d          = rcvd_q + 4'd1;
            remaining_d     = remaining_q - 4'd1;
            if (remaining_q == 4'd1) begin
               state_d = WAIT_BE;
            end
         end else begin
            err_evt = 1'b1;
         end
      end

      run_err_d = err_sticky ? (run_err | err_evt) : err_evt;
   end

   always_ff @(posedge tlx_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q            <= IDLE;
         remaining_q        <= 4'd0;
         rcvd_q             <= 4'd0;
         ctl_flit_start     <= 1'b0;
         run_length         <= 4'd0;
         bookend_flit_v     <= 1'b0;
         bad_data_indicator <= 8'd0;
         data_flit_v        <= 1'b0;
         data_flit_idx      <= 3'd0;
         run_err            <= 1'b0;
      end else begin
         state_q            <= state_d;
         remaining_q        <= remaining_d;
         rcvd_q             <= rcvd_d;
         ctl_flit_start     <= ctl_flit_start_d;
         run_length         <= run_length_d;
         bookend_flit_v     <= bookend_flit_v_d;
         bad_data_indicator <= bad_data_indicator_d;
         data_flit_v        <= data_flit_v_d;
         data_flit_idx      <= data_flit_idx_d;
         run_err            <= run_err_d;
      end
   end

endmodule

// File: tb/tb_ocx_tlx_data_run_ctl.sv
// tb/tb_ocx_tlx_data_run_ctl.sv - directed and random checks of ocx_tlx_data_run_ctl against a run model
module tb_ocx_tlx_data_run_ctl;

   logic       tlx_clk = 1'b0;
   logic       reset_n;
   logic       flit_v, flit_is_ctl, crc_error;
   logic [3:0] ctl_run_length;
   logic [7:0] ctl_bdi;

   logic       p_start, p_be, p_dv, p_err;
   logic [3:0] p_len;
   logic [7:0] p_bdi;
   logic [2:0] p_idx;
   logic       s_start, s_be, s_dv, s_err;
   logic [3:0] s_len;
   logic [7:0] s_bdi;
   logic [2:0] s_idx;

   int passed = 0;
   int total  = 0;

   // Model: length announced by the open run (0 = none) and data flits taken so far.
   int ann = 0;
   int got = 0;
   logic sticky = 1'b0;

   always #5 tlx_clk = ~tlx_clk;

   ocx_tlx_data_run_ctl #(.max_run(4'd8), .err_sticky(1'b0)) dut_p (
      .tlx_clk(tlx_clk), .reset_n(reset_n), .flit_v(flit_v), .flit_is_ctl(flit_is_ctl),
      .ctl_run_length(ctl_run_length), .ctl_bdi(ctl_bdi), .crc_error(crc_error),
      .ctl_flit_start(p_start), .run_length(p_len), .bookend_flit_v(p_be),
      .bad_data_indicator(p_bdi), .data_flit_v(p_dv), .data_flit_idx(p_idx), .run_err(p_err));

   ocx_tlx_data_run_ctl #(.max_run(4'd8), .err_sticky(1'b1)) dut_s (
      .tlx_clk(tlx_clk), .reset_n(reset_n), .flit_v(flit_v), .flit_is_ctl(flit_is_ctl),
      .ctl_run_length(ctl_run_length), .ctl_bdi(ctl_bdi), .crc_error(crc_error),
      .ctl_flit_start(s_start), .run_length(s_len), .bookend_flit_v(s_be),
      .bad_data_indicator(s_bdi), .data_flit_v(s_dv), .data_flit_idx(s_idx), .run_err(s_err));

   task automatic check(input string tag, input logic [18:0] exp_p, input logic [18:0] exp_s);
      logic [18:0] obs_p, obs_s;
      obs_p = {p_start, p_len, p_be, p_bdi, p_dv, p_idx, p_err};
      obs_s = {s_start, s_len, s_be, s_bdi, s_dv, s_idx, s_err};
      total++;
      assert (obs_p === exp_p) passed++;
      else $error("FAIL %s pulse-mode outputs observed=%h expected=%h", tag, obs_p, exp_p);
      total++;
      assert (obs_s === exp_s) passed++;
      else $error("FAIL %s sticky-mode outputs observed=%h expected=%h", tag, obs_s, exp_s);
   endtask

   task automatic step(input logic v, input logic ctl, input logic [3:0] len,
                       input logic [7:0] bdi, input logic crc, input string tag);
      logic       e_start, e_be, e_dv, e_evt;
      logic [3:0] e_len;
      logic [7:0] e_bdi;
      logic [2:0] e_idx;
      @(negedge tlx_clk);
      flit_v = v; flit_is_ctl = ctl; ctl_run_length = len; ctl_bdi = bdi; crc_error = crc;
      e_start = 0; e_be = 0; e_dv = 0; e_evt = 0; e_len = 0; e_bdi = 0; e_idx = 0;
      if (crc) begin
         ann = 0; got = 0;
      end else if (v && ctl) begin
         e_start = 1;
         if (got > 0) begin
            e_be = 1;
            for (int n = 0; n < 8; n++) if (n < got) e_bdi[n] = bdi[n];
         end
         if (ann > 0 && got < ann) e_evt = 1;
         ann = 0; got = 0;
         if (len >= 1 && len <= 8) begin
            e_len = len; ann = int'(len);
         end else if (len > 8) begin
            e_evt = 1;
         end
      end else if (v) begin
         if (ann > 0 && got < ann) begin
            e_dv = 1; e_idx = 3'(got); got++;
         end else begin
            e_evt = 1;
         end
      end
      sticky = sticky | e_evt;
      @(posedge tlx_clk);
      #1;
      check(tag, {e_start, e_len, e_be, e_bdi, e_dv, e_idx, e_evt},
                 {e_start, e_len, e_be, e_bdi, e_dv, e_idx, sticky});
   endtask

   task automatic ctl_f(input logic [3:0] len, input logic [7:0] bdi, input string tag);
      step(1'b1, 1'b1, len, bdi, 1'b0, tag);
   endtask

   task automatic data_f(input string tag);
      step(1'b1, 1'b0, 4'd0, 8'd0, 1'b0, tag);
   endtask

   task automatic idle(input string tag);
      step(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, tag);
   endtask

   // Asynchronous reset taken between clock edges; outputs must clear before the next edge.
   task automatic async_reset(input string tag);
      @(negedge tlx_clk);
      flit_v = 0; flit_is_ctl = 0; ctl_run_length = 0; ctl_bdi = 0; crc_error = 0;
      #2 reset_n = 1'b0;
      #1;
      ann = 0; got = 0; sticky = 1'b0;
      check(tag, 19'd0, 19'd0);
      @(negedge tlx_clk);
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0;
      flit_v = 0; flit_is_ctl = 0; ctl_run_length = 0; ctl_bdi = 0; crc_error = 0;
      repeat (2) @(posedge tlx_clk);
      #1;
      check("reset", 19'd0, 19'd0);
      @(negedge tlx_clk);
      reset_n = 1'b1;

      ctl_f(4'd3, 8'h00, "t1_ctl3");
      data_f("t1_d0"); data_f("t1_d1"); data_f("t1_d2");
      ctl_f(4'd0, 8'hFA, "t1_bookend");
      idle("t1_idle");

      ctl_f(4'd8, 8'h00, "t2_ctl8");
      for (int i = 0; i < 8; i++) data_f("t2_data");
      ctl_f(4'd2, 8'hFF, "t2_bookend");
      data_f("t2_new_d0");

      ctl_f(4'd4, 8'h00, "t3_ctl4");
      data_f("t3_d0"); data_f("t3_d1");
      ctl_f(4'd1, 8'h0F, "t3_premature");

      ctl_f(4'd2, 8'h00, "t4_ctl2");
      data_f("t4_d0");
      step(1'b1, 1'b0, 4'd0, 8'd0, 1'b1, "t4_crc");
      ctl_f(4'd0, 8'hFF, "t4_no_bookend");
      data_f("t4_data_idle");

      async_reset("t5_pre_reset");
      ctl_f(4'd9, 8'h00, "t5_len9");
      idle("t5_hold1"); idle("t5_hold2");
      ctl_f(4'd15, 8'h55, "t5_len15");
      ctl_f(4'd1, 8'h00, "t5_len1");
      data_f("t5_d0");
      data_f("t5_data_wait_be");
      ctl_f(4'd0, 8'h81, "t5_bookend");

      ctl_f(4'd4, 8'h00, "t6_ctl4");
      data_f("t6_d0");
      async_reset("t6_midrun_reset");
      data_f("t6_data_after_reset");

      for (int i = 0; i < 400; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 3)
            step(1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom), 1'b1, "rand_crc");
         else if (r < 25)
            ctl_f(4'($urandom_range(0, 10)), 8'($urandom), "rand_ctl");
         else if (r < 88)
            data_f("rand_data");
         else if (r < 99)
            idle("rand_idle");
         else
            async_reset("rand_reset");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
